// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch with PC register and a 2-entry decode queue.
//            Optional static branch predecode under FETCH_BRANCH_PREDECODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0]  c_full = 2'd2;
  localparam logic [31:0] c_step = 32'd4;

  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic [31:0] r_instr [0:1];
  logic [31:0] r_addr  [0:1];

  logic        w_pop;
  logic        w_push;
  logic [31:0] w_seq_pc;
  logic [31:0] w_next_pc;
  logic        w_unused_ok;

  assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

  assign imem_addr = r_pc;
  assign if_valid  = (r_count != 2'd0);
  assign if_instr  = r_instr[0];
  assign if_pc     = r_addr[0];

  assign w_pop    = if_valid && id_ready;
  // A pop always frees a slot, so every pop coincides with a push.
  assign w_push   = (r_count != c_full) || w_pop;
  assign w_seq_pc = r_pc + c_step;

`ifdef FETCH_BRANCH_PREDECODE_EN
  logic        w_is_br;
  logic [31:0] w_br_off;

  assign w_is_br   = (imem_instr[31:27] == 5'b00011);
  assign w_br_off  = {{3{imem_instr[26]}}, imem_instr[26:0], 2'b00};
  assign w_next_pc = w_is_br ? (w_seq_pc + w_br_off) : w_seq_pc;
`else
  assign w_next_pc = w_seq_pc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_count    <= 2'd0;
      r_instr[0] <= 32'd0;
      r_instr[1] <= 32'd0;
      r_addr[0]  <= 32'd0;
      r_addr[1]  <= 32'd0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
      r_pc    <= {redirect_pc[31:2], 2'b00};
    end else if (w_push) begin
      r_pc <= w_next_pc;
      if (w_pop) begin
        if (r_count == c_full) begin
          r_instr[0] <= r_instr[1];
          r_addr[0]  <= r_addr[1];
          r_instr[1] <= imem_instr;
          r_addr[1]  <= r_pc;
        end else begin
          r_instr[0] <= imem_instr;
          r_addr[0]  <= r_pc;
        end
      end else begin
        if (r_count == 2'd0) begin
          r_instr[0] <= imem_instr;
          r_addr[0]  <= r_pc;
        end else begin
          r_instr[1] <= imem_instr;
          r_addr[1]  <= r_pc;
        end
        r_count <= r_count + 2'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total;
  int bad;
  logic br_on;

  fetch_unit #(.RESET_PC(32'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: opcode field 10100 never looks like a branch.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  always_comb begin
    if (br_on && imem_addr == 32'd8) imem_instr = 32'h1800_0001;
    else                             imem_instr = mem_word(imem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic ready);
    rst_n          = 1'b0;
    id_ready       = ready;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    br_on = 1'b0;
    apply_reset(1'b0);
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'd0); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    total++; if (if_instr !== 32'd0 || if_pc !== 32'd0) begin bad++; $display("FAIL reset_head got instr=%h pc=%h exp 0/0", if_instr, if_pc); end
    step();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin bad++; $display("FAIL first_push got v=%b pc=%h exp v=1 pc=0", if_valid, if_pc); end
    total++; if (if_instr !== 32'hA500_0000) begin bad++; $display("FAIL first_instr got=%h exp=a5000000", if_instr); end
    total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL first_addr got=%h exp=4", imem_addr); end
  endtask

  task automatic test_stream();
    br_on = 1'b0;
    apply_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== mem_word(32'(4 * i))) begin
        bad++;
        $display("FAIL stream_%0d got v=%b pc=%h instr=%h exp v=1 pc=%h", i, if_valid, if_pc, if_instr, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    br_on = 1'b0;
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    total++; if (imem_addr !== 32'd8) begin bad++; $display("FAIL stall_addr got=%h exp=8", imem_addr); end
    total++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin bad++; $display("FAIL stall_head got v=%b pc=%h exp v=1 pc=0", if_valid, if_pc); end
    id_ready = 1'b1;
    step();
    total++; if (if_pc !== 32'd4 || imem_addr !== 32'd12) begin bad++; $display("FAIL stall_rel1 got pc=%h addr=%h exp pc=4 addr=c", if_pc, imem_addr); end
    step();
    total++; if (if_pc !== 32'd8 || if_instr !== 32'hA500_0008) begin bad++; $display("FAIL stall_rel2 got pc=%h instr=%h exp pc=8", if_pc, if_instr); end
  endtask

  task automatic test_redirect();
    br_on = 1'b0;
    apply_reset(1'b0);
    step(); step(); step();
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    step();
    redirect_valid = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got v=%b exp=0", if_valid); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h exp=40", imem_addr); end
    step();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'hA500_0040) begin bad++; $display("FAIL redir_head got v=%b pc=%h instr=%h exp pc=40", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_branch();
    logic [31:0] exp_addr;
`ifdef FETCH_BRANCH_PREDECODE_EN
    exp_addr = 32'd16;
`else
    exp_addr = 32'd12;
`endif
    br_on = 1'b1;
    apply_reset(1'b1);
    step(); step(); step();
    total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL branch_addr got=%h exp=%h", imem_addr, exp_addr); end
    total++; if (if_pc !== 32'd8 || if_instr !== 32'h1800_0001) begin bad++; $display("FAIL branch_head got pc=%h instr=%h exp pc=8 instr=18000001", if_pc, if_instr); end
    br_on = 1'b0;
  endtask

  task automatic test_wrap();
    br_on = 1'b0;
    apply_reset(1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin bad++; $display("FAIL wrap_pre got addr=%h v=%b exp addr=fffffffc v=0", imem_addr, if_valid); end
    step();
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    total++; if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'hA5FF_FFFC) begin bad++; $display("FAIL wrap_head got pc=%h instr=%h exp pc=fffffffc", if_pc, if_instr); end
  endtask

  task automatic test_reset_full();
    br_on = 1'b0;
    apply_reset(1'b0);
    step(); step(); step();
    total++; if (imem_addr !== 32'd8 || if_valid !== 1'b1) begin bad++; $display("FAIL rstfull_pre got addr=%h v=%b exp addr=8 v=1", imem_addr, if_valid); end
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_addr !== 32'd0) begin bad++; $display("FAIL rstfull got v=%b addr=%h exp v=0 addr=0", if_valid, imem_addr); end
    total++; if (if_instr !== 32'd0 || if_pc !== 32'd0) begin bad++; $display("FAIL rstfull_head got instr=%h pc=%h exp 0/0", if_instr, if_pc); end
    rst_n = 1'b1;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    br_on          = 1'b0;
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_branch();
    test_wrap();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port imem_addr  output  32  fetch address to instruction memory; always equals the PC register.
REQ-005 SHALL have port imem_instr  input  32  instruction word returned combinationally for imem_addr, sampled at the next clk edge.
REQ-006 SHALL have port if_valid  output  1  queue head holds a valid instruction for decode.
REQ-007 SHALL have port if_instr  output  32  queue-head instruction word.
REQ-008 SHALL have port if_pc  output  32  address the queue-head instruction was fetched from.
REQ-009 SHALL have port id_ready  input  1  decode accepts the head this cycle.
REQ-010 SHALL have port redirect_valid  input  1  execute-stage PC redirect request (taken branch/jump).
REQ-011 SHALL have port redirect_pc  input  32  redirect target address.

Function
REQ-012 SHALL hold a 32-bit PC register and a 2-entry FIFO of {instr, pc} pairs with a 2-bit occupancy count (0..2).
REQ-013 SHALL drive if_valid=1 exactly when count>0, with if_instr/if_pc taken from the head entry, no combinational path from imem_instr.
REQ-014 SHALL pop the head on a clock edge where if_valid && id_ready.
REQ-015 SHALL push {imem_instr, PC} and advance PC on an edge where count<2, or count==2 with a pop the same edge (simultaneous push+pop keeps count at 2).
REQ-016 SHALL hold PC and perform no push when the FIFO is full and no pop occurs.
REQ-017 SHALL compute the sequential next PC as PC+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-018 SHALL, on an edge with redirect_valid=1, empty the FIFO (count=0), load PC with {redirect_pc[31:2],2'b00}, and suppress push and pop that edge; redirect has priority over every other event.
REQ-019 SHALL preserve program order: instructions leave the FIFO in fetch order with no duplication or loss absent redirect.
REQ-020 SHALL give one-cycle fetch-to-decode latency: an instruction pushed at edge N is visible on if_instr after edge N when the FIFO was empty.

Reset
REQ-021 SHALL, on a clock edge with rst_n=0, set PC=RESET_PC, count=0, FIFO contents=0, so imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0 after that edge.
REQ-022 SHALL apply reset with priority over redirect, push and pop, including mid-stream and while full.

Configuration
REQ-023 SHALL, when macro FETCH_BRANCH_PREDECODE_EN is defined, detect a pushed instruction with imem_instr[31:27]==5'b00011 (br) and load PC with PC+4+(sign-extended imem_instr[26:0] << 2) instead of PC+4; the branch word is still pushed to decode.
REQ-024 SHALL, when FETCH_BRANCH_PREDECODE_EN is undefined, always use PC+4 and rely solely on redirect_valid for control flow.

Verification
REQ-025 SHALL cover: rst_n=0 for 2 cycles, RESET_PC=0 -> imem_addr=0, if_valid=0; first edge after release pushes addr 0, if_valid=1, if_pc=0.
REQ-026 SHALL cover: id_ready=1 continuously -> if_pc sequence 0,4,8,12 one per cycle, no bubbles.
REQ-027 SHALL cover: id_ready=0 for 5 cycles from reset -> count saturates at 2, imem_addr holds at 8, if_pc stays 0; release -> 0,4,8 delivered in order.
REQ-028 SHALL cover: redirect_valid=1, redirect_pc=0x43 while full and id_ready=1 -> next cycle if_valid=0, imem_addr=0x40; following cycle if_pc=0x40.
REQ-029 SHALL cover: br word 0x18000001 at addr 8 -> with macro next imem_addr=16; without macro next imem_addr=12.
REQ-030 SHALL cover: PC=0xFFFFFFFC, FIFO not full -> next imem_addr=0x00000000; rst_n=0 asserted with FIFO full -> if_valid=0, imem_addr=RESET_PC after one edge.
